block_memory_arbiter: RTL and testbench
=======================================

# block_memory_arbiter

Shares one single-clock, registered-read `block_memory` instance between two requesters: the instruction-fetch port and the load/store data port. Arbitrates per cycle with round-robin priority and routes each one-cycle-latency read response back to its owner. Sequences sub-word stores as a two-cycle read-modify-write, because the memory has no byte enables. Sits between the core's fetch/LSU stages and the memory macro.

## Interface
- `ADDRESS_SIZE`, default 10: word-address width; must match the memory instance.
- `WORD_SIZE`, default 32: data width; must be a multiple of 8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req_valid` in 1: fetch read request.
- `fetch_req_ready` out 1: fetch request accepted this cycle.
- `fetch_address` in ADDRESS_SIZE: fetch word address.
- `fetch_resp_valid` out 1: fetch read data valid.
- `fetch_resp_data` out WORD_SIZE: fetch read data.
- `data_req_valid` in 1: load/store request.
- `data_req_ready` out 1: data request accepted this cycle.
- `data_write` in 1: 1 = store, 0 = load.
- `data_address` in ADDRESS_SIZE: data word address.
- `data_write_data` in WORD_SIZE: store data.
- `data_byte_mask` in WORD_SIZE/8: store byte enables; bit i covers bits [8i+7:8i].
- `data_resp_valid` out 1: load data valid.
- `data_resp_data` out WORD_SIZE: load data.
- `mem_read_enable`, `mem_write_enable` out 1: to the memory.
- `mem_read_address`, `mem_write_address` out ADDRESS_SIZE: to the memory.
- `mem_write_data` out WORD_SIZE: to the memory.
- `mem_read_data` in WORD_SIZE: from the memory; registered, valid the cycle after a read enable.

## Operation
- States: IDLE, RMW_MERGE.
- **IDLE**: grant at most one request per cycle.
  - A request is accepted when `valid && ready`. `ready` is combinational from valid, state and priority.
  - Both valid: the grant goes to the port not granted last. The last-grant bit updates only on a grant.
- **Fetch grant, or data load grant**:
  - `mem_read_enable` = 1 with the request address.
  - Next cycle: the owner's `resp_valid` = 1.
- **Data store, mask all ones**: `mem_write_enable` = 1, address and data passed through. Completes in 1 cycle with no response.
- **Data store, mask zero**: accepted, no memory access, no response.
- **Data store, partial mask**:
  - Accept cycle: issue a read, latch address, data and mask, then go to RMW_MERGE.
  - RMW_MERGE: merge `mem_read_data` with the latched data per mask, assert `mem_write_enable`, return to IDLE.
  - Both readies are 0 in RMW_MERGE.
  - The RMW's read produces no `resp_valid`.
- Back-to-back reads: one per cycle, fully pipelined. `resp_valid` follows each accepted read by exactly one cycle.
- Responses have no backpressure; requesters always accept them.
- `*_resp_data` equals `mem_read_data` combinationally. It is meaningful only while the matching `resp_valid` is 1.
- Ordering: a write at cycle N is visible to a read issued at N+1 or later. Only one grant is made per cycle, so no same-cycle read/write conflict exists.

## Timing
- Reset values:
  - State IDLE; last-grant = data, so fetch wins the first tie.
  - Both `resp_valid` 0.
  - All `mem_*` enables 0 while `reset` is high.
  - Both readies 0 while `reset` is high.
- Read latency: 1 cycle from acceptance to `resp_valid`.
- Full-word store: 1 cycle. Partial store: 2 cycles, blocking both ports for the second.
- Reset mid-RMW: the pending merge write is dropped and memory is unchanged.
- Reset with a read in flight: its `resp_valid` is suppressed.
- `valid` may drop without acceptance; no request is held internally before acceptance.

## Structure
- Shared package holds:
  - state encoding (IDLE, RMW_MERGE);
  - port-id constants (PORT_FETCH = 0, PORT_DATA = 1);
  - a byte-merge function taking (old, new, mask) and returning the merged word.
- Registers: state, last-grant bit, in-flight owner, in-flight-valid, latched RMW address/data/mask.
- One sub-module: `round_robin_arbiter_2`, a two-requester grant with last-grant pointer and advance-on-grant.

## Test plan
- Reset, then fetch reads 0x010 (preloaded with 0xDEADBEEF) and data reads 0x020 (0x12345678) in the same cycle:
  - cycle 0: fetch granted;
  - cycle 1: `fetch_resp_data` = 0xDEADBEEF, and data granted;
  - cycle 2: `data_resp_data` = 0x12345678.
- Both ports continuously valid for 8 cycles: grants strictly alternate F,D,F,D…, and each `resp_valid` lands exactly 1 cycle after its grant.
- Full store 0xCAFEF00D to 0x005 (mask 0xF), then load 0x005 on the next cycle: response 0xCAFEF00D; the store takes 1 cycle.
- Word 0x005 = 0x11223344, store 0xAABBCCDD with mask 0b0101:
  - 2-cycle store with both readies 0 in RMW_MERGE;
  - a subsequent load returns 0x11BB33DD;
  - a fetch held valid throughout is granted only after the merge.
- Store with mask 0: accepted in 1 cycle, no memory write; the word is unchanged on readback.
- Assert `reset` during RMW_MERGE: no memory write occurs, the word reads back unchanged, and every output is at its reset value the cycle after.

Source files
------------

// File: rtl/block_memory_arbiter_pkg.sv
// Shared definitions for the block memory arbiter: FSM encoding, requester
// identifiers and the byte-merge helper used by the read-modify-write path.
package block_memory_arbiter_pkg;

  // FSM encoding
  localparam logic [0:0] STATE_IDLE      = 1'b0;
  localparam logic [0:0] STATE_RMW_MERGE = 1'b1;

  // Requester identifiers (also the last-grant / in-flight owner encoding)
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_WORD_SIZE = 32'd256;
  localparam int MAX_BYTES     = 32'd32;

  // Replace each byte of old_word whose mask bit is set with the byte of new_word.
  function automatic logic [MAX_WORD_SIZE-1:0] byte_merge(
    input logic [MAX_WORD_SIZE-1:0] old_word,
    input logic [MAX_WORD_SIZE-1:0] new_word,
    input logic [MAX_BYTES-1:0]     mask
  );
    logic [MAX_WORD_SIZE-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/block_memory_arbiter_round_robin.sv
// Two-requester round-robin grant. On a tie the requester not granted last
// wins; the last-grant pointer advances only when a grant is actually made.
module round_robin_arbiter_2
  import block_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] request,
  output logic [1:0] grant
);

  logic       last_grant_r;
  logic [1:0] grant_s;

  // Select at most one requester; bit 0 is fetch, bit 1 is data.
  always_comb begin
    grant_s = 2'b00;
    if (enable) begin
      case (request)
        2'b11:   grant_s = (last_grant_r == PORT_DATA) ? 2'b01 : 2'b10;
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // Remember who was served last; reset favours fetch on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= PORT_DATA;
    end else if (grant_s[0]) begin
      last_grant_r <= PORT_FETCH;
    end else if (grant_s[1]) begin
      last_grant_r <= PORT_DATA;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/block_memory_arbiter.sv
// Shares one registered-read block memory between the fetch port and the
// load/store port. Reads are pipelined one per cycle; sub-word stores are
// done as a read followed by a merged write, stalling both ports one cycle.
module block_memory_arbiter
  import block_memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE = 10,
  parameter int WORD_SIZE    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_req_valid,
  output logic                      fetch_req_ready,
  input  logic [ADDRESS_SIZE-1:0]   fetch_address,
  output logic                      fetch_resp_valid,
  output logic [WORD_SIZE-1:0]      fetch_resp_data,
  input  logic                      data_req_valid,
  output logic                      data_req_ready,
  input  logic                      data_write,
  input  logic [ADDRESS_SIZE-1:0]   data_address,
  input  logic [WORD_SIZE-1:0]      data_write_data,
  input  logic [WORD_SIZE/8-1:0]    data_byte_mask,
  output logic                      data_resp_valid,
  output logic [WORD_SIZE-1:0]      data_resp_data,
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  output logic [ADDRESS_SIZE-1:0]   mem_read_address,
  output logic [ADDRESS_SIZE-1:0]   mem_write_address,
  output logic [WORD_SIZE-1:0]      mem_write_data,
  input  logic [WORD_SIZE-1:0]      mem_read_data
);

  localparam int BYTE_COUNT = WORD_SIZE / 8;

  logic [0:0]              state_r;
  logic [0:0]              state_next_s;
  logic                    inflight_valid_r;
  logic                    inflight_owner_r;
  logic [ADDRESS_SIZE-1:0] rmw_address_r;
  logic [WORD_SIZE-1:0]    rmw_data_r;
  logic [BYTE_COUNT-1:0]   rmw_mask_r;

  logic [1:0]              grant_s;
  logic                    arb_enable_s;
  logic                    issue_resp_s;
  logic                    issue_owner_s;
  logic                    latch_rmw_s;
  logic [WORD_SIZE-1:0]    merged_s;

  // Grants are only possible in IDLE and never while reset is held.
  assign arb_enable_s = (state_r == STATE_IDLE) && !reset;

  round_robin_arbiter_2 u_arbiter (
    .clk     (clk),
    .reset   (reset),
    .enable  (arb_enable_s),
    .request ({data_req_valid, fetch_req_valid}),
    .grant   (grant_s)
  );

  assign fetch_req_ready = grant_s[0];
  assign data_req_ready  = grant_s[1];

  // Old word from the RMW read overlaid with the latched store bytes.
  assign merged_s = WORD_SIZE'(byte_merge(MAX_WORD_SIZE'(mem_read_data),
                                          MAX_WORD_SIZE'(rmw_data_r),
                                          MAX_BYTES'(rmw_mask_r)));

  // Drive the memory port and choose the next state from the grant.
  always_comb begin
    mem_read_enable   = 1'b0;
    mem_write_enable  = 1'b0;
    mem_read_address  = fetch_address;
    mem_write_address = data_address;
    mem_write_data    = data_write_data;
    state_next_s      = state_r;
    issue_resp_s      = 1'b0;
    issue_owner_s     = PORT_FETCH;
    latch_rmw_s       = 1'b0;
    case (state_r)
      STATE_IDLE: begin
        if (grant_s[0]) begin
          mem_read_enable  = 1'b1;
          mem_read_address = fetch_address;
          issue_resp_s     = 1'b1;
          issue_owner_s    = PORT_FETCH;
        end else if (grant_s[1]) begin
          if (!data_write) begin
            mem_read_enable  = 1'b1;
            mem_read_address = data_address;
            issue_resp_s     = 1'b1;
            issue_owner_s    = PORT_DATA;
          end else if (&data_byte_mask) begin
            mem_write_enable = 1'b1;
          end else if (|data_byte_mask) begin
            // Partial store: fetch the old word, merge it next cycle.
            mem_read_enable  = 1'b1;
            mem_read_address = data_address;
            latch_rmw_s      = 1'b1;
            state_next_s     = STATE_RMW_MERGE;
          end else begin
            // Empty mask: accepted but nothing to write.
            mem_write_enable = 1'b0;
          end
        end else begin
          state_next_s = STATE_IDLE;
        end
      end
      STATE_RMW_MERGE: begin
        mem_write_enable  = 1'b1;
        mem_write_address = rmw_address_r;
        mem_write_data    = merged_s;
        state_next_s      = STATE_IDLE;
      end
      default: begin
        state_next_s = STATE_IDLE;
      end
    endcase
    // Reset drops any pending merge write and keeps the memory quiet.
    if (reset) begin
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      issue_resp_s     = 1'b0;
      latch_rmw_s      = 1'b0;
    end else begin
      latch_rmw_s = latch_rmw_s;
    end
  end

  // State, in-flight read tracking and the latched partial store.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= STATE_IDLE;
      inflight_valid_r <= 1'b0;
      inflight_owner_r <= PORT_FETCH;
      rmw_address_r    <= {ADDRESS_SIZE{1'b0}};
      rmw_data_r       <= {WORD_SIZE{1'b0}};
      rmw_mask_r       <= {BYTE_COUNT{1'b0}};
    end else begin
      state_r          <= state_next_s;
      inflight_valid_r <= issue_resp_s;
      inflight_owner_r <= issue_owner_s;
      if (latch_rmw_s) begin
        rmw_address_r <= data_address;
        rmw_data_r    <= data_write_data;
        rmw_mask_r    <= data_byte_mask;
      end else begin
        rmw_address_r <= rmw_address_r;
        rmw_data_r    <= rmw_data_r;
        rmw_mask_r    <= rmw_mask_r;
      end
    end
  end

  // Responses follow the issuing read by one cycle; reset suppresses them.
  assign fetch_resp_valid = inflight_valid_r && (inflight_owner_r == PORT_FETCH) && !reset;
  assign data_resp_valid  = inflight_valid_r && (inflight_owner_r == PORT_DATA) && !reset;
  assign fetch_resp_data  = mem_read_data;
  assign data_resp_data   = mem_read_data;

endmodule

// File: tb/tb_block_memory_arbiter.sv
// Directed scoreboard bench for block_memory_arbiter with a behavioural
// registered-read memory model.
module tb_block_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req_valid, fetch_req_ready, fetch_resp_valid;
  logic [9:0]  fetch_address;
  logic [31:0] fetch_resp_data;
  logic        data_req_valid, data_req_ready, data_write, data_resp_valid;
  logic [9:0]  data_address;
  logic [31:0] data_write_data, data_resp_data;
  logic [3:0]  data_byte_mask;
  logic        mem_read_enable, mem_write_enable;
  logic [9:0]  mem_read_address, mem_write_address;
  logic [31:0] mem_write_data, mem_read_data;

  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:1023];

  int pass_cnt = 0;
  int check_cnt = 0;
  logic [31:0] fetch_q[$];
  logic [31:0] data_q[$];

  always #5 clk = ~clk;

  block_memory_arbiter #(.ADDRESS_SIZE(10), .WORD_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_address(fetch_address), .fetch_resp_valid(fetch_resp_valid),
    .fetch_resp_data(fetch_resp_data),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_write(data_write), .data_address(data_address),
    .data_write_data(data_write_data), .data_byte_mask(data_byte_mask),
    .data_resp_valid(data_resp_valid), .data_resp_data(data_resp_data),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Registered-read memory model with a bench-only preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
    if (mem_read_enable) mem_read_data <= mem[mem_read_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (fetch_resp_valid) begin
      if (fetch_q.size() == 0) begin
        check_cnt++;
        $display("FAIL fetch_resp_unexpected: got response %h, expected none", fetch_resp_data);
      end else begin
        check("fetch_resp_data", fetch_resp_data, fetch_q.pop_front());
      end
    end
    if (data_resp_valid) begin
      if (data_q.size() == 0) begin
        check_cnt++;
        $display("FAIL data_resp_unexpected: got response %h, expected none", data_resp_data);
      end else begin
        check("data_resp_data", data_resp_data, data_q.pop_front());
      end
    end
  end

  task automatic set_data(input logic v, input logic w, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    data_req_valid = v; data_write = w; data_address = a;
    data_write_data = d; data_byte_mask = m;
  endtask

  initial begin
    logic exp_f, prev_f;
    reset = 1'b1; pre_we = 1'b0; pre_addr = 10'h000; pre_data = 32'h0;
    fetch_req_valid = 1'b0; fetch_address = 10'h000;
    set_data(1'b0, 1'b0, 10'h000, 32'h0, 4'h0);

    // Preload while reset holds the DUT idle.
    next_cycle(); pre_we = 1'b1; pre_addr = 10'h010; pre_data = 32'hDEADBEEF;
    next_cycle(); pre_addr = 10'h020; pre_data = 32'h12345678;
    next_cycle(); pre_we = 1'b0;
    fetch_req_valid = 1'b1; fetch_address = 10'h010;
    set_data(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    @(negedge clk);
    check("reset_fetch_ready", 32'(fetch_req_ready), 32'd0);
    check("reset_data_ready", 32'(data_req_ready), 32'd0);
    check("reset_mem_re", 32'(mem_read_enable), 32'd0);
    check("reset_mem_we", 32'(mem_write_enable), 32'd0);
    check("reset_fetch_resp_valid", 32'(fetch_resp_valid), 32'd0);
    check("reset_data_resp_valid", 32'(data_resp_valid), 32'd0);

    // Simultaneous fetch and load: fetch wins the first tie.
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("t1_fetch_ready", 32'(fetch_req_ready), 32'd1);
    check("t1_data_ready", 32'(data_req_ready), 32'd0);
    check("t1_mem_re", 32'(mem_read_enable), 32'd1);
    check("t1_mem_raddr", 32'(mem_read_address), 32'h010);
    fetch_q.push_back(32'hDEADBEEF);
    next_cycle(); fetch_req_valid = 1'b0;
    @(negedge clk);
    check("t1_data_ready_c1", 32'(data_req_ready), 32'd1);
    check("t1_fetch_resp_valid_c1", 32'(fetch_resp_valid), 32'd1);
    data_q.push_back(32'h12345678);
    next_cycle(); data_req_valid = 1'b0;
    @(negedge clk);
    check("t1_data_resp_valid_c2", 32'(data_resp_valid), 32'd1);
    check("t1_fetch_resp_valid_c2", 32'(fetch_resp_valid), 32'd0);

    // Both ports continuously valid: strict alternation, 1-cycle responses.
    prev_f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      fetch_req_valid = 1'b1; fetch_address = 10'h010;
      set_data(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
      exp_f = ((i % 2) == 0);
      @(negedge clk);
      check("t2_fetch_ready", 32'(fetch_req_ready), 32'(exp_f));
      check("t2_data_ready", 32'(data_req_ready), 32'(!exp_f));
      if (exp_f) fetch_q.push_back(32'hDEADBEEF);
      else data_q.push_back(32'h12345678);
      if (i > 0) begin
        check("t2_fetch_resp_valid", 32'(fetch_resp_valid), 32'(prev_f));
        check("t2_data_resp_valid", 32'(data_resp_valid), 32'(!prev_f));
      end
      prev_f = exp_f;
    end
    next_cycle(); fetch_req_valid = 1'b0; data_req_valid = 1'b0;
    @(negedge clk);
    check("t2_last_data_resp_valid", 32'(data_resp_valid), 32'd1);
    check("t2_last_fetch_resp_valid", 32'(fetch_resp_valid), 32'd0);

    // Full-word store then immediate load.
    next_cycle(); set_data(1'b1, 1'b1, 10'h005, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    check("t3_store_ready", 32'(data_req_ready), 32'd1);
    check("t3_mem_we", 32'(mem_write_enable), 32'd1);
    check("t3_mem_re", 32'(mem_read_enable), 32'd0);
    check("t3_mem_waddr", 32'(mem_write_address), 32'h005);
    check("t3_mem_wdata", mem_write_data, 32'hCAFEF00D);
    next_cycle(); set_data(1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    @(negedge clk);
    check("t3_load_ready", 32'(data_req_ready), 32'd1);
    check("t3_store_no_resp", 32'(data_resp_valid), 32'd0);
    data_q.push_back(32'hCAFEF00D);

    // Partial store with RMW; fetch held valid from the merge cycle on.
    next_cycle(); data_req_valid = 1'b0;
    pre_we = 1'b1; pre_addr = 10'h005; pre_data = 32'h11223344;
    next_cycle(); pre_we = 1'b0;
    set_data(1'b1, 1'b1, 10'h005, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    check("t4_store_ready", 32'(data_req_ready), 32'd1);
    check("t4_rmw_read", 32'(mem_read_enable), 32'd1);
    check("t4_rmw_raddr", 32'(mem_read_address), 32'h005);
    check("t4_accept_no_write", 32'(mem_write_enable), 32'd0);
    next_cycle(); data_req_valid = 1'b0;
    fetch_req_valid = 1'b1; fetch_address = 10'h010;
    @(negedge clk);
    check("t4_merge_fetch_ready", 32'(fetch_req_ready), 32'd0);
    check("t4_merge_data_ready", 32'(data_req_ready), 32'd0);
    check("t4_merge_we", 32'(mem_write_enable), 32'd1);
    check("t4_merge_waddr", 32'(mem_write_address), 32'h005);
    check("t4_merge_wdata", mem_write_data, 32'h11BB33DD);
    check("t4_rmw_no_resp", 32'(data_resp_valid), 32'd0);
    next_cycle(); set_data(1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    @(negedge clk);
    check("t4_fetch_after_merge", 32'(fetch_req_ready), 32'd1);
    check("t4_data_waits", 32'(data_req_ready), 32'd0);
    check("t4_mem_word", mem[5], 32'h11BB33DD);
    fetch_q.push_back(32'hDEADBEEF);
    next_cycle(); fetch_req_valid = 1'b0;
    @(negedge clk);
    check("t4_load_ready", 32'(data_req_ready), 32'd1);
    data_q.push_back(32'h11BB33DD);

    // Zero-mask store: accepted, no memory access, word unchanged.
    next_cycle(); set_data(1'b1, 1'b1, 10'h005, 32'hFFFFFFFF, 4'h0);
    @(negedge clk);
    check("t5_ready", 32'(data_req_ready), 32'd1);
    check("t5_no_we", 32'(mem_write_enable), 32'd0);
    check("t5_no_re", 32'(mem_read_enable), 32'd0);
    next_cycle(); set_data(1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    @(negedge clk);
    check("t5_load_ready", 32'(data_req_ready), 32'd1);
    check("t5_no_resp", 32'(data_resp_valid), 32'd0);
    data_q.push_back(32'h11BB33DD);

    // Reset asserted during RMW_MERGE: merge write dropped.
    next_cycle(); set_data(1'b1, 1'b1, 10'h005, 32'h00000000, 4'b0011);
    @(negedge clk);
    check("t6_store_ready", 32'(data_req_ready), 32'd1);
    next_cycle(); data_req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t6_reset_no_we", 32'(mem_write_enable), 32'd0);
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("t6_after_fetch_resp", 32'(fetch_resp_valid), 32'd0);
    check("t6_after_data_resp", 32'(data_resp_valid), 32'd0);
    check("t6_after_we", 32'(mem_write_enable), 32'd0);
    check("t6_after_re", 32'(mem_read_enable), 32'd0);
    check("t6_mem_unchanged", mem[5], 32'h11BB33DD);
    next_cycle(); set_data(1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    fetch_req_valid = 1'b1; fetch_address = 10'h010;
    @(negedge clk);
    check("t6_fetch_first_after_reset", 32'(fetch_req_ready), 32'd1);
    fetch_q.push_back(32'hDEADBEEF);
    next_cycle(); fetch_req_valid = 1'b0;
    @(negedge clk);
    check("t6_idle_load_ready", 32'(data_req_ready), 32'd1);
    data_q.push_back(32'h11BB33DD);

    // Reset while a read is in flight suppresses its response.
    next_cycle(); data_req_valid = 1'b0;
    fetch_req_valid = 1'b1; fetch_address = 10'h010;
    @(negedge clk);
    check("t7_fetch_ready", 32'(fetch_req_ready), 32'd1);
    next_cycle(); fetch_req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t7_resp_suppressed", 32'(fetch_resp_valid), 32'd0);
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("t7_resp_still_quiet", 32'(fetch_resp_valid), 32'd0);

    next_cycle();
    next_cycle();
    @(negedge clk);
    check("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
    check("data_queue_drained", 32'(data_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
